error_injection_scheduler: RTL

Sequencer that drives the shared `err_en` / `err_ctrl` broadcast bus consumed by every error-injection control router slice. It walks a programmed range of error-site codes and holds each code active for a dwell time, followed by a quiet gap. The range can repeat for a set number of passes. A host-side start/abort/busy/done handshake controls it, and it reports invalid configurations.

---
 rtl/errinj_pkg.sv | 25 ++
 rtl/errinj_down_counter.sv | 27 ++
 rtl/error_injection_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/errinj_pkg.sv
// Shared types and default widths for the error-injection scheduler.
package errinj_pkg;

  localparam int unsigned ERRINJ_CTRL_W = 16;
  localparam int unsigned ERRINJ_CNT_W  = 16;
  localparam int unsigned ERRINJ_PASS_W = 8;

  localparam logic [ERRINJ_CTRL_W-1:0] ERRINJ_NO_SITE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_INJECT,
    ST_GAP,
    ST_DONE
  } errinj_state_t;

  // A repeat count of zero still runs one pass.
  function automatic logic [ERRINJ_PASS_W-1:0] errinj_repeat_eff(
    input logic [ERRINJ_PASS_W-1:0] rep
  );
    return (rep == '0) ? ERRINJ_PASS_W'(1) : rep;
  endfunction

endpackage

// File: rtl/errinj_down_counter.sv
// Loadable down counter with a zero flag; time-shared between dwell and gap.
module errinj_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/error_injection_scheduler.sv
// Walks a range of error-site codes onto the err_en/err_ctrl broadcast bus.
// Optional build macro ERRINJ_TRIGGER_EN adds a trig input that gates ARM.
module error_injection_scheduler
  import errinj_pkg::*;
#(
  parameter int unsigned CTRL_W = ERRINJ_CTRL_W,
  parameter int unsigned CNT_W  = ERRINJ_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
`ifdef ERRINJ_TRIGGER_EN
  input  logic                     trig,
`endif
  input  logic [CTRL_W-1:0]        cfg_first,
  input  logic [CTRL_W-1:0]        cfg_last,
  input  logic [CNT_W-1:0]         cfg_dwell,
  input  logic [CNT_W-1:0]         cfg_gap,
  input  logic [ERRINJ_PASS_W-1:0] cfg_repeat,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_bad,
  output logic [ERRINJ_PASS_W-1:0] pass_cnt,
  output logic                     err_en,
  output logic [CTRL_W-1:0]        err_ctrl
);

  localparam logic [CTRL_W-1:0] NO_SITE = CTRL_W'(ERRINJ_NO_SITE);
  localparam int unsigned       PCMP_W  = ERRINJ_PASS_W + 1;

  errinj_state_t              r_state;
  logic [CTRL_W-1:0]          r_first;
  logic [CTRL_W-1:0]          r_last;
  logic [CNT_W-1:0]           r_dwell;
  logic [CNT_W-1:0]           r_gap;
  logic [ERRINJ_PASS_W-1:0]   r_repeat;
  logic [CTRL_W-1:0]          r_code;
  logic [ERRINJ_PASS_W-1:0]   r_pass;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_cfg_bad;
  logic                       r_err_en;
  logic [CTRL_W-1:0]          r_err_ctrl;

  logic                       w_cfg_bad_c;
  logic                       w_arm_go;
  logic [CNT_W-1:0]           w_dwell_m1;
  logic [CNT_W-1:0]           w_gap_m1;
  logic                       w_cnt_load;
  logic [CNT_W-1:0]           w_cnt_val;
  logic                       w_cnt_dec;
  logic                       w_cnt_zero;
  logic                       w_at_last;
  logic                       w_more_pass;
  logic [CTRL_W-1:0]          w_code_inc;
  errinj_state_t              w_adv_state;
  logic [CTRL_W-1:0]          w_adv_code;
  logic [ERRINJ_PASS_W-1:0]   w_adv_pass;
  logic [CTRL_W-1:0]          w_adv_ctrl;

  assign w_cfg_bad_c = (cfg_first == '0) || (cfg_first > cfg_last);

`ifdef ERRINJ_TRIGGER_EN
  assign w_arm_go = trig;
`else
  assign w_arm_go = 1'b1;
`endif

  // Counter preloads are one less than the cycle count; it exits on zero.
  assign w_dwell_m1 = (r_dwell == '0) ? '0 : (r_dwell - CNT_W'(1));
  assign w_gap_m1   = r_gap - CNT_W'(1);

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = w_dwell_m1;
    w_cnt_dec  = 1'b0;
    case (r_state)
      ST_ARM: w_cnt_load = 1'b1;
      ST_INJECT: begin
        if (w_cnt_zero) begin
          w_cnt_load = (r_gap != '0);
          w_cnt_val  = w_gap_m1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_GAP: w_cnt_dec = !w_cnt_zero;
      default: ;
    endcase
  end

  errinj_down_counter #(
    .W (CNT_W)
  ) u_cnt (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero_c   (w_cnt_zero)
  );

  // Compare against last before incrementing so the top code never wraps.
  assign w_at_last   = (r_code == r_last);
  assign w_more_pass = ((PCMP_W'(r_pass) + PCMP_W'(1)) < PCMP_W'(errinj_repeat_eff(r_repeat)));
  assign w_code_inc  = r_code + CTRL_W'(1);

  always_comb begin
    w_adv_state = ST_DONE;
    w_adv_code  = r_code;
    w_adv_pass  = r_pass;
    if (!w_at_last) begin
      w_adv_state = ST_ARM;
      w_adv_code  = w_code_inc;
    end else if (w_more_pass) begin
      w_adv_state = ST_ARM;
      w_adv_code  = r_first;
      w_adv_pass  = r_pass + ERRINJ_PASS_W'(1);
    end
    w_adv_ctrl = (w_adv_state == ST_ARM) ? w_adv_code : NO_SITE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_first    <= '0;
      r_last     <= '0;
      r_dwell    <= '0;
      r_gap      <= '0;
      r_repeat   <= '0;
      r_code     <= '0;
      r_pass     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_bad  <= 1'b0;
      r_err_en   <= 1'b0;
      r_err_ctrl <= NO_SITE;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state    <= ST_IDLE;
        r_busy     <= 1'b0;
        r_err_en   <= 1'b0;
        r_err_ctrl <= NO_SITE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_err_en   <= 1'b0;
            r_err_ctrl <= NO_SITE;
            if (start) begin
              r_first   <= cfg_first;
              r_last    <= cfg_last;
              r_dwell   <= cfg_dwell;
              r_gap     <= cfg_gap;
              r_repeat  <= cfg_repeat;
              r_code    <= cfg_first;
              r_pass    <= '0;
              r_busy    <= 1'b1;
              r_cfg_bad <= w_cfg_bad_c;
              if (w_cfg_bad_c) begin
                r_state <= ST_DONE;
              end else begin
                r_state    <= ST_ARM;
                r_err_ctrl <= cfg_first;
              end
            end
          end
          ST_ARM: begin
            if (w_arm_go) begin
              r_state  <= ST_INJECT;
              r_err_en <= 1'b1;
            end
          end
          ST_INJECT: begin
            if (w_cnt_zero) begin
              r_err_en <= 1'b0;
              if (r_gap != '0) begin
                r_state    <= ST_GAP;
                r_err_ctrl <= NO_SITE;
              end else begin
                r_state    <= w_adv_state;
                r_code     <= w_adv_code;
                r_pass     <= w_adv_pass;
                r_err_ctrl <= w_adv_ctrl;
              end
            end
          end
          ST_GAP: begin
            if (w_cnt_zero) begin
              r_state    <= w_adv_state;
              r_code     <= w_adv_code;
              r_pass     <= w_adv_pass;
              r_err_ctrl <= w_adv_ctrl;
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_err_en   <= 1'b0;
            r_err_ctrl <= NO_SITE;
          end
        endcase
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign cfg_bad  = r_cfg_bad;
  assign pass_cnt = r_pass;
  assign err_en   = r_err_en;
  assign err_ctrl = r_err_ctrl;

endmodule
